// File: rtl/i2c_master.sv
// Single-transaction I2C initiator: START, 7-bit address + R/W, one data byte, ACK handling, STOP.
// SCL/SDA are open-drain outputs: *_oe=1 pulls the line low, 0 releases it to the pull-up.
module i2c_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
  } state_e;

  state_e        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    qtr_q,     qtr_d;
  logic [2:0]    bit_q,     bit_d;
  logic          rw_q,      rw_d;
  logic [6:0]    addr_q,    addr_d;
  logic [7:0]    wdata_q,   wdata_d;
  logic [7:0]    rdata_q,   rdata_d;
  logic          ack_err_q, ack_err_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          scl_oe_q,  scl_oe_d;
  logic          sda_oe_q,  sda_oe_d;
  logic          tick;
  logic [7:0]    addr_byte;

  assign tick      = (state_q != S_IDLE) && (cnt_q == CW'(CLK_DIV - 1));
  assign addr_byte = {addr_q, rw_q};

  // Next-state logic: every phase advance is gated by the quarter tick.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = (state_q == S_IDLE || tick) ? '0 : cnt_q + CW'(1);
    if (tick) qtr_d = qtr_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_START;
          qtr_d     = '0;
          bit_d     = 3'd7;
          rw_d      = rw;
          addr_d    = addr;
          wdata_d   = wdata;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (tick && qtr_q == 2'd1) begin
          state_d = S_ADDR;
          qtr_d   = '0;
        end
      end
      S_ADDR: begin
        // bit index wraps 0 -> 7, leaving it ready for the data byte
        if (tick && qtr_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = S_AACK;
          bit_d = bit_q - 3'd1;
        end
      end
      S_AACK: begin
        if (tick && qtr_q == 2'd2 && sda_i) ack_err_d = 1'b1;
        if (tick && qtr_q == 2'd3) state_d = ack_err_q ? S_STOP : S_DATA;
      end
      S_DATA: begin
        if (tick && qtr_q == 2'd2 && rw_q) rdata_d = {rdata_q[6:0], sda_i};
        if (tick && qtr_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = S_DACK;
          bit_d = bit_q - 3'd1;
        end
      end
      S_DACK: begin
        if (tick && qtr_q == 2'd2 && !rw_q && sda_i) ack_err_d = 1'b1;
        if (tick && qtr_q == 2'd3) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick && qtr_q == 2'd2) begin
          state_d = S_IDLE;
          qtr_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pad drive for the upcoming quarter, registered so the open-drain pins never glitch.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      S_START: begin
        scl_oe_d = (qtr_d == 2'd1);
        sda_oe_d = 1'b1;
      end
      S_ADDR: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ~addr_byte[bit_d];
      end
      S_AACK, S_DACK: scl_oe_d = ~qtr_d[1];
      S_DATA: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ~rw_q & ~wdata_q[bit_d];
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (sys_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: timed bench slave, bus-level decoder and a
// transaction-level model of latency, ack_err, rdata and the bit stream on the wire.
module tb_i2c_master;

  localparam int D = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       sda_i = 1'b1;
  logic       scl_oe, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_master #(.CLK_DIV(D)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .sda_i   (sda_i),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rdata   (rdata)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Bench slave: drives SDA by quarter index since accept (34..37 addr ACK,
  // 38..69 read data, 70..73 write-data ACK).
  logic       arm = 1'b0;
  logic       slv_on = 1'b0;
  int         t = 0;
  logic       s_rw = 1'b0, ack_a = 1'b0, ack_d = 1'b0;
  logic [7:0] s_rbyte = '0;
  logic       slave_pull;
  logic       sda_bus;
  logic       sda_s1 = 1'b1;

  always @(posedge sys_clk) begin
    if (arm) begin
      t      <= 0;
      slv_on <= 1'b1;
    end else if (sys_rst) begin
      slv_on <= 1'b0;
    end else begin
      t <= t + 1;
    end
  end

  always_comb begin
    int q;
    q = t / D;
    slave_pull = 1'b0;
    if (slv_on) begin
      if (q >= 34 && q <= 37)
        slave_pull = ack_a;
      else if (s_rw && ack_a && q >= 38 && q <= 69)
        slave_pull = ~s_rbyte[3'(7 - (q - 38) / 4)];
      else if (!s_rw && ack_a && q >= 70 && q <= 73)
        slave_pull = ack_d;
    end
  end

  assign sda_bus = ~(sda_oe | slave_pull);

  always @(posedge sys_clk) begin
    sda_s1 <= sda_bus;
    sda_i  <= sda_s1;
  end

  // Bus decoder: bit taken at SCL rise, committed at the following fall; STOP discards it.
  logic        pscl = 1'b1, psda = 1'b1, pend_v = 1'b0, pend_b = 1'b0;
  int          n_start = 0, n_stop = 0, mon_n = 0;
  logic [31:0] mon_bits = '0;

  always @(negedge sys_clk) begin
    logic scl, sda;
    scl = ~scl_oe;
    sda = sda_bus;
    if (pscl && scl && psda && !sda) begin
      n_start++;
      mon_n = 0;
      mon_bits = '0;
      pend_v = 1'b0;
    end else if (pscl && scl && !psda && sda) begin
      n_stop++;
      pend_v = 1'b0;
    end else if (!pscl && scl) begin
      pend_v = 1'b1;
      pend_b = sda;
    end else if (pscl && !scl && pend_v) begin
      mon_bits = {mon_bits[30:0], pend_b};
      mon_n++;
      pend_v = 1'b0;
    end
    pscl = scl;
    psda = sda;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_rdata = '0;
  int         acc_cyc, b_start, b_stop;

  task automatic launch(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_wdata,
                        input logic i_ack_a, input logic i_ack_d, input logic [7:0] i_rbyte,
                        input string tag);
    @(negedge sys_clk);
    s_rw    = i_rw;
    ack_a   = i_ack_a;
    ack_d   = i_ack_d;
    s_rbyte = i_rbyte;
    rw      = i_rw;
    addr    = i_addr;
    wdata   = i_wdata;
    start   = 1'b1;
    arm     = 1'b1;
    acc_cyc = cyc;
    b_start = n_start;
    b_stop  = n_stop;
    @(negedge sys_clk);
    start = 1'b0;
    arm   = 1'b0;
    // scramble the request inputs to prove they were latched at accept
    rw    = ~i_rw;
    addr  = ~i_addr;
    wdata = ~i_wdata;
    check({tag, ".busy_acc"}, busy, 1'b1);
    check({tag, ".err_clr"}, ack_err, 1'b0);
  endtask

  task automatic run_txn(input logic i_rw, input logic [6:0] i_addr, input logic [7:0] i_wdata,
                         input logic i_ack_a, input logic i_ack_d, input logic [7:0] i_rbyte,
                         input logic poke, input string tag);
    logic        seen;
    int          lat;
    int          exp_lat, exp_n;
    logic        exp_err;
    logic [31:0] exp_bits;
    logic [7:0]  dbyte;

    exp_lat = (i_ack_a ? 77 : 41) * D + 1;
    exp_err = !i_ack_a || (!i_rw && !i_ack_d);
    dbyte   = i_rw ? i_rbyte : i_wdata;
    if (i_ack_a) begin
      exp_n    = 18;
      exp_bits = {14'b0, i_addr, i_rw, 1'b0, dbyte, (i_rw ? 1'b1 : ~i_ack_d)};
    end else begin
      exp_n    = 9;
      exp_bits = {23'b0, i_addr, i_rw, 1'b1};
    end
    if (i_rw && i_ack_a) exp_rdata = i_rbyte;

    launch(i_rw, i_addr, i_wdata, i_ack_a, i_ack_d, i_rbyte, tag);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        seen = 1'b1;
        lat  = cyc - acc_cyc;
        break;
      end
      start = poke && (i == 40);
      @(negedge sys_clk);
    end
    start = 1'b0;

    check({tag, ".done_seen"}, seen, 1'b1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".busy_done"}, busy, 1'b0);
    check({tag, ".ack_err"}, ack_err, exp_err);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".n_start"}, n_start - b_start, 1);
    check({tag, ".n_stop"}, n_stop - b_stop, 1);
    check({tag, ".n_bits"}, mon_n, exp_n);
    check({tag, ".bits"}, mon_bits, exp_bits);
    @(negedge sys_clk);
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".err_held"}, ack_err, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    rw      = 1'b0;
    addr    = '0;
    wdata   = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst.scl_oe", scl_oe, 1'b0);
    check("rst.sda_oe", sda_oe, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.ack_err", ack_err, 1'b0);
    check("rst.rdata", rdata, 8'h00);

    run_txn(1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, "wr_ack");
    run_txn(1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, "rd_3c");
    run_txn(1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, "wr_noslave");
    run_txn(1'b0, 7'h50, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, "wr_dnack");
    run_txn(1'b0, 7'h50, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, "wr_poke");
    run_txn(1'b1, 7'h27, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b1, "rd_poke");

    // abort during the data phase, bit 3
    launch(1'b0, 7'h50, 8'h96, 1'b1, 1'b1, 8'h00, "abort");
    repeat (51 * D) @(negedge sys_clk);
    check("abort.busy_mid", busy, 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("abort.scl_oe", scl_oe, 1'b0);
    check("abort.sda_oe", sda_oe, 1'b0);
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.rdata", rdata, 8'h00);
    sys_rst   = 1'b0;
    exp_rdata = '0;
    repeat (3) @(negedge sys_clk);
    run_txn(1'b0, 7'h50, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, "post_abort");

    for (int k = 0; k < 8; k++) begin
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), ($urandom % 4) != 0,
              ($urandom % 3) != 0, 8'($urandom), ($urandom % 3) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-transaction I2C controller: the initiating end of the bus our slave receives on.
- Generates START, 7-bit address + R/W, one data byte (write or read), ACK handling and STOP.
- Drives open-drain SCL/SDA via output-enable pins; the pad ring provides the pull-ups.
- Used as a bench/loopback initiator for the slave and as a host-side controller.

Parameters:
- CLK_DIV, 250: sys_clk cycles per SCL quarter-period. Minimum 2. Default gives 100 kHz at 100 MHz.

Ports:
- sys_clk  in  1  system clock; all logic on posedge.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- rw  in  1  0 = write, 1 = read; latched at accept.
- addr  in  7  slave address; latched at accept.
- wdata  in  8  write byte; latched at accept.
- sda_i  in  1  sampled SDA pad level; the bench must synchronise it.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse at end of transaction.
- ack_err  out  1  a NACK was seen (address or write data); valid at done; held until the next accept.
- rdata  out  8  read byte, MSB first; valid at done; held.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, state IDLE, quarter counter 0.
- Quarter timer:
  - Counter runs 0..CLK_DIV-1 while not IDLE.
  - tick = (count == CLK_DIV-1).
  - All phase/state advances happen on tick.
- Accept:
  - In IDLE with start=1: latch rw/addr/wdata, clear ack_err, busy=1 next cycle, counter starts from 0.
  - start while busy is ignored, with no queueing.
- States and quarter sequences (per-quarter values of scl_oe/sda_oe):
  - IDLE: 0/0.
  - START, 2 quarters: Q0 scl 0/sda 1; Q1 scl 1/sda 1.
  - ADDR, 8 bits of {addr, rw}, MSB first, 4 quarters each:
    - Q0 and Q1: scl_oe=1; sda_oe = ~bit, set at Q0 entry.
    - Q2 and Q3: scl_oe=0, SDA held.
  - AACK, 4 quarters, sda_oe=0, SCL as a bit:
    - sda_i is sampled on the tick ending Q2; 1 means NACK.
    - NACK: set ack_err and go to STOP.
    - ACK: go to DATA.
  - DATA, 8 bits:
    - Write: drive wdata as ADDR.
    - Read: sda_oe=0; shift sda_i into rdata on the tick ending Q2, MSB first.
  - DACK, 4 quarters:
    - Write: release SDA and sample as AACK; NACK sets ack_err.
    - Read: master sends NACK (sda_oe=0); ack_err is unchanged.
    - Then STOP.
  - STOP, 3 quarters: Q0 scl 1/sda 1; Q1 scl 0/sda 1; Q2 scl 0/sda 0.
  - Then done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- SDA only changes while SCL is driven low, except the START and STOP edges.
- Transaction length:
  - Full: 2+32+4+32+4+3 = 77 quarters, i.e. done occurs 77*CLK_DIV+1 cycles after the accept cycle.
  - Address NACK: 2+32+4+3 = 41 quarters.
- A new start is allowed in the done cycle's following cycle (IDLE).
- Reset mid-transaction: next edge returns to reset values. Both lines are released and no STOP is generated; this is accepted.
- No clock stretching and no arbitration; SCL is never sampled.

Test Plan:
- CLK_DIV=4, write addr=0x50, wdata=0xA5, bench slave ACKs both:
  - bus decodes START, 0xA0, ACK, 0xA5, ACK, STOP.
  - done 309 cycles after accept; ack_err=0.
- Read addr=0x50, bench slave ACKs address and drives 0x3C:
  - bus carries 0xA1; master NACKs the data.
  - rdata=0x3C, ack_err=0 at done.
- Write with sda_i held high (no slave):
  - STOP follows the address ACK slot; no data bits.
  - done at 41*4+1 cycles after accept; ack_err=1.
- Write addr=0x50, wdata=0x11, slave ACKs address and NACKs data:
  - all 77 quarters are run; ack_err=1.
- start pulsed again mid-transaction with different addr:
  - ignored; the original transaction completes unchanged.
  - A second start after done is accepted and ack_err clears.
- Assert sys_rst during DATA bit 3:
  - next cycle scl_oe=0, sda_oe=0, busy=0, done=0.
  - A following start runs a full transaction correctly.
